sprite_line_scheduler: RTL

SPRITE_LINE_SCHEDULER -- requirements
Module: sprite_line_scheduler

---
 rtl/sprite_line_scheduler_pkg.sv | 21 ++
 rtl/sprite_line_scheduler_hit_eval.sv | 25 ++
 rtl/sprite_line_scheduler.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/sprite_line_scheduler_pkg.sv
// Shared definitions for the sprite line scheduler.
// Holds the object-entry byte layout, the FSM state encoding and the default sizes.
// No logic lives here.
package sprite_line_scheduler_pkg;

  localparam int DEFAULT_NUM_OBJ   = 8;
  localparam int DEFAULT_NUM_SLOTS = 4;

  // Object entry layout: {size, offset, y, x}
  localparam int OBJ_X_LSB    = 0;
  localparam int OBJ_Y_LSB    = 8;
  localparam int OBJ_OFS_LSB  = 16;
  localparam int OBJ_SIZE_LSB = 24;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SCAN    = 2'd1,
    ST_PUBLISH = 2'd2
  } state_e;

endpackage

// File: rtl/sprite_line_scheduler_hit_eval.sv
// Vertical hit test of one object entry against the scanline being prepared.
// Purely combinational, zero latency.
// No flow control.
module sprite_hit_eval (
  input  logic [7:0] obj_y_i,
  input  logic [3:0] obj_size_i,
  input  logic [7:0] line_y_i,
  output logic       hit_o,
  output logic [3:0] row_o
);

  logic [8:0] y_lo;
  logic [8:0] y_hi;
  logic [8:0] line_y;

  // Nine-bit compare so an object near the bottom never wraps onto row 0.
  assign y_lo   = {1'b0, obj_y_i};
  assign y_hi   = y_lo + {5'd0, obj_size_i} + 9'd1;
  assign line_y = {1'b0, line_y_i};
  assign hit_o  = (line_y >= y_lo) && (line_y < y_hi);

  // A hit row is below 16, so the low nibble of the difference is exact.
  assign row_o  = line_y_i[3:0] - obj_y_i[3:0];

endmodule

// File: rtl/sprite_line_scheduler.sv
// Scans the object table during hblank and publishes up to NUM_SLOTS sprite hits for the next line.
// done is asserted NUM_OBJ+2 cycles after the accepted line_start. Optional macro: SPRITE_SCHED_OVF_IRQ_EN (ovf_irq pulse).
// No backpressure: a line_start that arrives while busy is dropped and flagged in overrun; abort cancels a scan.
module sprite_line_scheduler
  import sprite_line_scheduler_pkg::*;
#(
  parameter int NUM_OBJ   = DEFAULT_NUM_OBJ,
  parameter int NUM_SLOTS = DEFAULT_NUM_SLOTS
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 line_start,
  input  logic [7:0]                           next_y,
  input  logic                                 abort,
  output logic                                 obj_rd_en,
  output logic [$clog2(NUM_OBJ)-1:0]           obj_addr,
  input  logic [31:0]                          obj_data,
  output logic                                 busy,
  output logic                                 done,
  output logic [NUM_SLOTS-1:0]                 slot_valid,
  output logic [NUM_SLOTS*$clog2(NUM_OBJ)-1:0] slot_index,
  output logic [NUM_SLOTS*4-1:0]               slot_row,
  output logic                                 overflow,
  output logic                                 overrun,
  input  logic                                 clr_status,
  output logic                                 ovf_irq
);

  localparam int IW = $clog2(NUM_OBJ);
  localparam int CW = $clog2(NUM_SLOTS + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_OBJ - 1);

  state_e                 state_q, state_d;
  logic [7:0]             y_q;
  logic                   rd_en_q;
  logic [IW-1:0]          addr_q;
  logic                   ev_vld_q;
  logic [IW-1:0]          ev_idx_q;
  logic [NUM_SLOTS-1:0]   wk_vld_q, wk_vld_d;
  logic [NUM_SLOTS*IW-1:0] wk_idx_q, wk_idx_d;
  logic [NUM_SLOTS*4-1:0] wk_row_q, wk_row_d;
  logic [CW-1:0]          wk_cnt_q, wk_cnt_d;
  logic                   wk_ovf_q, wk_ovf_d;
  logic                   done_q;
  logic [NUM_SLOTS-1:0]   out_vld_q;
  logic [NUM_SLOTS*IW-1:0] out_idx_q;
  logic [NUM_SLOTS*4-1:0] out_row_q;
  logic                   out_ovf_q;
  logic                   overrun_q;

  logic       hit;
  logic [3:0] row;
  logic       start;
  logic       last_ev;
  logic       publish;
  logic       ovr_set;
  logic       obj_unused;

  assign obj_unused = ^{obj_data[31:OBJ_SIZE_LSB+4], obj_data[OBJ_OFS_LSB +: 8],
                        obj_data[OBJ_X_LSB +: 8]};

  sprite_hit_eval u_hit_eval (
    .obj_y_i    (obj_data[OBJ_Y_LSB +: 8]),
    .obj_size_i (obj_data[OBJ_SIZE_LSB +: 4]),
    .line_y_i   (y_q),
    .hit_o      (hit),
    .row_o      (row)
  );

  assign start   = line_start && !abort && (state_q == ST_IDLE);
  assign ovr_set = line_start && !abort && (state_q != ST_IDLE);
  assign last_ev = ev_vld_q && (ev_idx_q == LAST_IDX);
  assign publish = last_ev && !abort;

  // Next state: scan until the last entry is evaluated, then one publish cycle; abort always wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_SCAN;
      ST_SCAN:    if (last_ev) state_d = ST_PUBLISH;
      ST_PUBLISH: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  // Working list: append each hit into the next free slot, mark overflow once slots run out.
  always_comb begin
    wk_vld_d = wk_vld_q;
    wk_idx_d = wk_idx_q;
    wk_row_d = wk_row_q;
    wk_cnt_d = wk_cnt_q;
    wk_ovf_d = wk_ovf_q;
    if (ev_vld_q && hit) begin
      if (wk_cnt_q < CW'(NUM_SLOTS)) begin
        for (int s = 0; s < NUM_SLOTS; s++) begin
          if (wk_cnt_q == CW'(s)) begin
            wk_vld_d[s]            = 1'b1;
            wk_idx_d[s*IW +: IW]   = ev_idx_q;
            wk_row_d[s*4 +: 4]     = row;
          end
        end
        wk_cnt_d = wk_cnt_q + 1'b1;
      end else begin
        wk_ovf_d = 1'b1;
      end
    end
  end

  // State, read sequencer, working list and published (held) outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      y_q       <= '0;
      rd_en_q   <= 1'b0;
      addr_q    <= '0;
      ev_vld_q  <= 1'b0;
      ev_idx_q  <= '0;
      wk_vld_q  <= '0;
      wk_idx_q  <= '0;
      wk_row_q  <= '0;
      wk_cnt_q  <= '0;
      wk_ovf_q  <= 1'b0;
      done_q    <= 1'b0;
      out_vld_q <= '0;
      out_idx_q <= '0;
      out_row_q <= '0;
      out_ovf_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ev_vld_q <= rd_en_q && !abort;
      ev_idx_q <= addr_q;
      if (start) begin
        y_q      <= next_y;
        rd_en_q  <= 1'b1;
        addr_q   <= '0;
        wk_vld_q <= '0;
        wk_idx_q <= '0;
        wk_row_q <= '0;
        wk_cnt_q <= '0;
        wk_ovf_q <= 1'b0;
      end else begin
        if (abort) begin
          rd_en_q <= 1'b0;
        end else if (rd_en_q) begin
          addr_q <= addr_q + 1'b1;
          if (addr_q == LAST_IDX) rd_en_q <= 1'b0;
        end
        wk_vld_q <= wk_vld_d;
        wk_idx_q <= wk_idx_d;
        wk_row_q <= wk_row_d;
        wk_cnt_q <= wk_cnt_d;
        wk_ovf_q <= wk_ovf_d;
      end
      done_q <= publish;
      if (publish) begin
        out_vld_q <= wk_vld_d;
        out_idx_q <= wk_idx_d;
        out_row_q <= wk_row_d;
        out_ovf_q <= wk_ovf_d;
      end
      if (ovr_set) overrun_q <= 1'b1;
      else if (clr_status) overrun_q <= 1'b0;
    end
  end

`ifdef SPRITE_SCHED_OVF_IRQ_EN
  logic irq_q;

  // Interrupt pulse alongside done whenever the list being published overflowed.
  always_ff @(posedge clk) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= publish && wk_ovf_d;
  end

  assign ovf_irq = irq_q;
`else
  assign ovf_irq = 1'b0;
`endif

  assign obj_rd_en  = rd_en_q;
  assign obj_addr   = addr_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign slot_valid = out_vld_q;
  assign slot_index = out_idx_q;
  assign slot_row   = out_row_q;
  assign overflow   = out_ovf_q;
  assign overrun    = overrun_q;

endmodule
